// File: rtl/midori_sbox_round_ctrl.sv
// Round sequencer for the second-order masked Midori64 core.
// It walks the 3-share state register through NUM_ROUNDS rounds around the
// registered masked S-box layer. A fresh PRNG word is consumed for every
// S-box evaluation. The state and S-box inputs are held stable while the
// S-box pipeline fills.
// Every datapath select is registered, apart from rand_ready. rand_ready
// must follow rand_valid in the same cycle so that the S-box register
// captures exactly on the handshake.
module midori_sbox_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int SBOX_LAT   = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rand_valid,
    output logic             rand_ready,
    output logic             load_en,
    output logic             state_en,
    output logic             whiten_en,
    output logic             final_round,
    output logic [CNT_W-1:0] round_idx,
    output logic             busy,
    output logic             done
);

    // pipe_cnt only needs to hold SBOX_LAT-2; keep at least one bit
    localparam int PIPE_W = (SBOX_LAT > 2) ? $clog2(SBOX_LAT - 1) : 1;
    localparam logic [PIPE_W-1:0] PIPE_INIT  = PIPE_W'((SBOX_LAT >= 2) ? (SBOX_LAT - 2) : 0);
    localparam logic [CNT_W-1:0]  LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SBOX = 3'd2,
        PIPE = 3'd3,
        UPD  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state_r;
    logic [PIPE_W-1:0] pipe_cnt_r;
    logic [CNT_W-1:0]  round_idx_r;
    logic              load_en_r;
    logic              state_en_r;
    logic              whiten_en_r;
    logic              final_round_r;
    logic              busy_r;
    logic              done_r;
    logic              last_round_s;

    assign last_round_s = (round_idx_r == LAST_ROUND);

    // Randomness is only taken while the S-box register is waiting to capture
    assign rand_ready  = (state_r == SBOX) && rand_valid;
    assign load_en     = load_en_r;
    assign state_en    = state_en_r;
    assign whiten_en   = whiten_en_r;
    assign final_round = final_round_r;
    assign round_idx   = round_idx_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Round FSM: outputs are registered with the values of the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            pipe_cnt_r    <= '0;
            round_idx_r   <= '0;
            load_en_r     <= 1'b0;
            state_en_r    <= 1'b0;
            whiten_en_r   <= 1'b0;
            final_round_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            // single-cycle strobes default low; the entered state re-asserts them
            load_en_r     <= 1'b0;
            state_en_r    <= 1'b0;
            whiten_en_r   <= 1'b0;
            final_round_r <= 1'b0;
            done_r        <= 1'b0;
            case (state_r)
                IDLE: begin
                    round_idx_r <= '0;
                    pipe_cnt_r  <= '0;
                    if (start) begin
                        state_r     <= LOAD;
                        load_en_r   <= 1'b1;
                        state_en_r  <= 1'b1;
                        whiten_en_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    state_r <= SBOX;
                end
                SBOX: begin
                    if (!rand_valid) begin
                        state_r <= SBOX;
                    end else if (SBOX_LAT == 1) begin
                        state_r       <= UPD;
                        state_en_r    <= 1'b1;
                        final_round_r <= last_round_s;
                        whiten_en_r   <= last_round_s;
                    end else begin
                        state_r    <= PIPE;
                        pipe_cnt_r <= PIPE_INIT;
                    end
                end
                PIPE: begin
                    if (pipe_cnt_r == '0) begin
                        state_r       <= UPD;
                        state_en_r    <= 1'b1;
                        final_round_r <= last_round_s;
                        whiten_en_r   <= last_round_s;
                    end else begin
                        state_r    <= PIPE;
                        pipe_cnt_r <= pipe_cnt_r - PIPE_W'(1);
                    end
                end
                UPD: begin
                    if (last_round_s) begin
                        // round_idx stays on the last round through DONE
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r     <= SBOX;
                        round_idx_r <= round_idx_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    // start is not looked at here, so back-to-back runs get one IDLE cycle
                    state_r     <= IDLE;
                    round_idx_r <= '0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    round_idx_r <= '0;
                    pipe_cnt_r  <= '0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
